// File: rtl/input_debouncer.sv
// input_debouncer: synchronise a raw level input and filter it for stability
module input_debouncer #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   PRESCALE     = 1,
  parameter int   STABLE_COUNT = 16,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out,
  output logic busy,
  output logic glitch
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  typedef enum logic {STABLE, PEND} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sff;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic out_nxt, glitch_nxt, sync, tick;
  assign sync = sff[SYNC_STAGES-1];
  assign tick = (PRESCALE == 1) || (pcnt == PW'(PRESCALE - 1));
  // synchroniser chain; nothing else looks at the raw input
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sff <= {SYNC_STAGES{RESET_VALUE}};
    else sff <= {sff[SYNC_STAGES-2:0], in};
  // free-running sample prescaler, independent of input activity
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + 1'b1;
  // filter next state: count consecutive differing ticks, abort on agreement
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    out_nxt    = out;
    glitch_nxt = 1'b0;
    if (tick && state == STABLE && sync != out) begin
      if (STABLE_COUNT == 1) out_nxt = sync;
      else begin
        cnt_nxt   = CW'(1);
        state_nxt = PEND;
      end
    end else if (tick && state == PEND) begin
      if (sync == out) begin
        cnt_nxt    = '0;
        state_nxt  = STABLE;
        glitch_nxt = 1'b1;
      end else if (cnt == CW'(STABLE_COUNT - 1)) begin
        out_nxt   = sync;
        cnt_nxt   = '0;
        state_nxt = STABLE;
      end else cnt_nxt = cnt + 1'b1;
    end
  end
  // filter state and registered outputs
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state  <= STABLE;
      cnt    <= '0;
      out    <= RESET_VALUE;
      busy   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      out    <= out_nxt;
      busy   <= state_nxt == PEND;
      glitch <= glitch_nxt;
    end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: three configurations checked cycle by cycle against a run-length model
module tb_input_debouncer;
  logic clk = 1'b0, rstn = 1'b0, in = 1'b0;
  logic [2:0] o, b, g;
  int pre[3] = '{1, 4, 1};
  int stc[3] = '{16, 3, 1};
  int nvec = 0, nerr = 0, edges = 0, run[3];
  bit m_out[3], m_gl[3];
  bit hist[$];
  always #5 clk = ~clk;

  input_debouncer u0 (.clk(clk), .rstn(rstn), .in(in), .out(o[0]), .busy(b[0]), .glitch(g[0]));
  input_debouncer #(.PRESCALE(4), .STABLE_COUNT(3)) u1 (.clk(clk), .rstn(rstn), .in(in), .out(o[1]), .busy(b[1]), .glitch(g[1]));
  input_debouncer #(.STABLE_COUNT(1)) u2 (.clk(clk), .rstn(rstn), .in(in), .out(o[2]), .busy(b[2]), .glitch(g[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: model the edge from the inputs the DUT sees, then compare at the falling edge
  task automatic step();
    @(posedge clk);
    if (!rstn) begin
      edges = 0;
      hist = '{1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
        m_out[i] = 1'b0; m_gl[i] = 1'b0; run[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_gl[i] = 1'b0;
        if (edges % pre[i] == pre[i] - 1) begin
          if (hist[0] != m_out[i]) begin
            run[i]++;
            if (run[i] == stc[i]) begin
              m_out[i] = hist[0];
              run[i] = 0;
            end
          end else begin
            m_gl[i] = run[i] > 0;
            run[i] = 0;
          end
        end
      end
      hist.push_back(in);
      void'(hist.pop_front());
      edges++;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out%0d", i), 32'(o[i]), 32'(m_out[i]));
      check($sformatf("busy%0d", i), 32'(b[i]), 32'(run[i] > 0));
      check($sformatf("glitch%0d", i), 32'(g[i]), 32'(m_gl[i]));
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // cycles until instance i shows level v on out, -1 if it never does
  task automatic lat(input int i, input bit v, output int n);
    n = -1;
    for (int k = 1; k <= 40 && n < 0; k++) begin
      step();
      if (o[i] == v) n = k;
    end
  endtask

  initial begin
    int n, e, gc;
    hist = '{1'b0, 1'b0};
    @(negedge clk);
    check("reset_out", 32'(o), 32'd0);
    check("reset_busy", 32'(b), 32'd0);
    check("reset_glitch", 32'(g), 32'd0);
    in = 1'b1;
    steps(5);
    rstn = 1'b1;
    in = 1'b0;
    steps(30);
    in = 1'b1;
    lat(0, 1'b1, n);
    check("rise_lat", n, 18);
    in = 1'b0;
    lat(0, 1'b0, n);
    check("fall_lat", n, 18);
    steps(20);
    gc = 0;
    for (int r = 0; r < 3; r++) begin
      in = 1'b1;
      for (int k = 0; k < 5; k++) begin step(); gc += int'(g[0]); end
      in = 1'b0;
      for (int k = 0; k < 12; k++) begin step(); gc += int'(g[0]); end
    end
    check("glitch_cnt", gc, 3);
    check("glitch_out", 32'(o[0]), 32'd0);
    steps(20);
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 4 && edges % 4 != ph; k++) step();
      e = 3;
      while ((ph + e - 1) % 4 != 3) e++;
      in = 1'b1;
      lat(1, 1'b1, n);
      check($sformatf("pre_lat_ph%0d", ph), n, e + 8);
      check($sformatf("pre_rng_ph%0d", ph), 32'(n >= 11 && n <= 14), 32'd1);
      in = 1'b0;
      steps(20);
    end
    in = 1'b1;
    steps(9);
    rstn = 1'b0;
    steps(2);
    check("mid_rst_out", 32'(o[0]), 32'd0);
    check("mid_rst_busy", 32'(b[0]), 32'd0);
    rstn = 1'b1;
    lat(0, 1'b1, n);
    check("post_rst_lat", n, 18);
    in = 1'b0;
    steps(20);
    for (int t = 0; t < 8; t++) begin
      in = ~in;
      lat(2, in, n);
      check("sc1_lat", n, 3);
      steps(4 - n);
    end
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        rstn = 1'b0;
        steps($urandom_range(1, 3));
        rstn = 1'b1;
      end
      in = 1'($urandom_range(0, 1));
      steps($urandom_range(1, 25));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
